// File: rtl/if_resp_queue.sv
// Fetch response tracker: pairs returning instructions with their issued addresses, in order.
// Optional drop counter port/logic enabled by defining IF_RESP_PERF_EN.
module if_resp_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              excp_flush,
    input  logic              ertn_flush,
    input  logic [ADDR_W-1:0] vaddr,
    input  logic              vaddr_valid,
    output logic              vaddr_ready,
    input  logic [INST_W-1:0] inst_i,
    input  logic              inst_valid,
    output logic              inst_ready,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] vaddr_o,
    output logic              ib_valid,
`ifdef IF_RESP_PERF_EN
    output logic [31:0]       perf_drop_cnt,
`endif
    input  logic              ib_ready
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]       wr_ptr, rd_ptr;
    logic [PW-1:0]     wr_idx, rd_idx;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DEPTH-1:0]  kill;
    logic [DEPTH-1:0]  occupied;
    logic [PW:0]       count;
    logic              full, empty, any_flush, head_kill;
    logic              enq, pop, drop, load;
    logic              out_valid;

    assign wr_idx    = wr_ptr[PW-1:0];
    assign rd_idx    = rd_ptr[PW-1:0];
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
    assign empty     = (wr_ptr == rd_ptr);
    assign any_flush = flush | excp_flush | ertn_flush;
    assign head_kill = kill[rd_idx];

    assign vaddr_ready = !full && !any_flush;
    assign inst_ready  = !empty && (head_kill || any_flush || !out_valid || ib_ready);

    assign enq  = vaddr_valid && vaddr_ready;
    assign pop  = inst_valid && inst_ready;
    assign drop = pop && (head_kill || any_flush);
    assign load = pop && !drop;

    assign count = wr_ptr - rd_ptr;

    // An index is occupied when its distance from the head is below the fill count.
    always_comb begin
        occupied = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupied[i] = ({1'b0, PW'(i) - rd_idx} < count);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            kill   <= '0;
        end else begin
            if (enq) begin
                wr_ptr       <= wr_ptr + 1'b1;
                kill[wr_idx] <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Enqueue is blocked in a flush cycle, so these never collide.
            if (any_flush) begin
                kill <= kill | occupied;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_idx] <= vaddr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            inst_o    <= '0;
            vaddr_o   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            inst_o    <= inst_i;
            vaddr_o   <= addr_mem[rd_idx];
        end else if (any_flush || ib_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign ib_valid = out_valid;

`ifdef IF_RESP_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_drop_cnt <= '0;
        end else if (drop && (perf_drop_cnt != '1)) begin
            perf_drop_cnt <= perf_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_resp_queue.sv
// Directed self-checking bench for if_resp_queue (DEPTH=4).
module tb_if_resp_queue;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush, excp_flush, ertn_flush;
    logic [ADDR_W-1:0] vaddr;
    logic              vaddr_valid;
    logic              vaddr_ready;
    logic [INST_W-1:0] inst_i;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] vaddr_o;
    logic              ib_valid;
    logic              ib_ready;
`ifdef IF_RESP_PERF_EN
    logic [31:0]       perf_drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_drops = 0;

    always #5 clk = ~clk;

    if_resp_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .excp_flush(excp_flush),
        .ertn_flush(ertn_flush),
        .vaddr(vaddr),
        .vaddr_valid(vaddr_valid),
        .vaddr_ready(vaddr_ready),
        .inst_i(inst_i),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_o(inst_o),
        .vaddr_o(vaddr_o),
        .ib_valid(ib_valid),
`ifdef IF_RESP_PERF_EN
        .perf_drop_cnt(perf_drop_cnt),
`endif
        .ib_ready(ib_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 0; excp_flush = 0; ertn_flush = 0;
        vaddr = '0; vaddr_valid = 0; inst_i = '0; inst_valid = 0; ib_ready = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({vaddr_ready, inst_ready, ib_valid} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl: got vr/ir/ibv=%b required 100", {vaddr_ready, inst_ready, ib_valid});
        end
        checks++;
        if (inst_o !== '0 || vaddr_o !== '0) begin
            failures++;
            $display("FAIL reset_data: got inst_o=%h vaddr_o=%h required 0/0", inst_o, vaddr_o);
        end
`ifdef IF_RESP_PERF_EN
        checks++;
        if (perf_drop_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_perf: got %0d required 0", perf_drop_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            vaddr = 32'h1C00_0000 + 32'(i * 4);
            vaddr_valid = 1'b1;
            #1;
            checks++;
            if (vaddr_ready !== 1'b1) begin
                failures++;
                $display("FAIL fill_ready%0d: got %b required 1", i, vaddr_ready);
            end
            tick();
        end
        vaddr = 32'h1C00_0010;
        vaddr_valid = 1'b1;
        #1;
        checks++;
        if (vaddr_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got vaddr_ready=%b required 0", vaddr_ready);
        end
        tick();
        vaddr_valid = 1'b0;
    endtask

    task automatic test_drain();
        ib_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_i = 32'hAAAA_0001 + 32'(i);
            inst_valid = 1'b1;
            #1;
            checks++;
            if (inst_ready !== 1'b1) begin
                failures++;
                $display("FAIL drain_iready%0d: got %b required 1", i, inst_ready);
            end
            tick();
            checks++;
            if (ib_valid !== 1'b1 || inst_o !== 32'hAAAA_0001 + 32'(i) || vaddr_o !== 32'h1C00_0000 + 32'(i * 4)) begin
                failures++;
                $display("FAIL drain_pair%0d: got v=%b inst=%h addr=%h required v=1 inst=%h addr=%h",
                         i, ib_valid, inst_o, vaddr_o, 32'hAAAA_0001 + 32'(i), 32'h1C00_0000 + 32'(i * 4));
            end
        end
        // FIFO now empty: a stray response is a protocol violation and must be refused.
        inst_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (inst_ready !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: got inst_ready=%b required 0", inst_ready);
        end
        tick();
        inst_valid = 1'b0;
        checks++;
        if (ib_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_taken: got ib_valid=%b required 0", ib_valid);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            vaddr = 32'h1C00_0100 + 32'(i * 4);
            vaddr_valid = 1'b1;
            tick();
        end
        vaddr = 32'h1C00_01F0;
        flush = 1'b1;
        #1;
        checks++;
        if (vaddr_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_vready: got %b required 0", vaddr_ready);
        end
        tick();
        flush = 1'b0;
        vaddr_valid = 1'b0;
        ib_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_i = 32'hCCCC_0001 + 32'(i);
            inst_valid = 1'b1;
            #1;
            checks++;
            if (inst_ready !== 1'b1) begin
                failures++;
                $display("FAIL flush_drain_iready%0d: got %b required 1", i, inst_ready);
            end
            tick();
            exp_drops++;
            checks++;
            if (ib_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_stale%0d: got ib_valid=%b required 0", i, ib_valid);
            end
        end
        inst_valid = 1'b0;
        vaddr = 32'h1C00_1000;
        vaddr_valid = 1'b1;
        tick();
        vaddr_valid = 1'b0;
        inst_i = 32'hBBBB_0000;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        checks++;
        if (ib_valid !== 1'b1 || inst_o !== 32'hBBBB_0000 || vaddr_o !== 32'h1C00_1000) begin
            failures++;
            $display("FAIL flush_live: got v=%b inst=%h addr=%h required v=1 inst=bbbb0000 addr=1c001000",
                     ib_valid, inst_o, vaddr_o);
        end
`ifdef IF_RESP_PERF_EN
        checks++;
        if (perf_drop_cnt !== 32'(exp_drops)) begin
            failures++;
            $display("FAIL flush_perf: got %0d required %0d", perf_drop_cnt, exp_drops);
        end
`endif
        tick();
    endtask

    task automatic test_stall();
        ib_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vaddr = 32'h1C00_0200 + 32'(i * 4);
            vaddr_valid = 1'b1;
            tick();
        end
        vaddr_valid = 1'b0;
        inst_i = 32'hDDDD_0001;
        inst_valid = 1'b1;
        tick();
        inst_i = 32'hDDDD_0002;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (inst_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_iready%0d: got %b required 0", c, inst_ready);
            end
            tick();
            checks++;
            if (ib_valid !== 1'b1 || inst_o !== 32'hDDDD_0001 || vaddr_o !== 32'h1C00_0200) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b inst=%h addr=%h required v=1 inst=dddd0001 addr=1c000200",
                         c, ib_valid, inst_o, vaddr_o);
            end
        end
        ib_ready = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: got inst_ready=%b required 1", inst_ready);
        end
        tick();
        inst_valid = 1'b0;
        checks++;
        if (ib_valid !== 1'b1 || inst_o !== 32'hDDDD_0002 || vaddr_o !== 32'h1C00_0204) begin
            failures++;
            $display("FAIL stall_second: got v=%b inst=%h addr=%h required v=1 inst=dddd0002 addr=1c000204",
                     ib_valid, inst_o, vaddr_o);
        end
        tick();
    endtask

    task automatic test_excp_flush();
        vaddr = 32'h1C00_0300;
        vaddr_valid = 1'b1;
        tick();
        vaddr = 32'h1C00_0304;
        inst_i = 32'hEEEE_0001;
        inst_valid = 1'b1;
        excp_flush = 1'b1;
        ib_ready = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b1 || vaddr_ready !== 1'b0) begin
            failures++;
            $display("FAIL excp_cycle: got ir=%b vr=%b required ir=1 vr=0", inst_ready, vaddr_ready);
        end
        tick();
        exp_drops++;
        excp_flush = 1'b0;
        vaddr_valid = 1'b0;
        checks++;
        if (ib_valid !== 1'b0) begin
            failures++;
            $display("FAIL excp_drop: got ib_valid=%b required 0", ib_valid);
        end
        // The address offered during the flush must not have been recorded.
        #1;
        checks++;
        if (inst_ready !== 1'b0) begin
            failures++;
            $display("FAIL excp_noenq: got inst_ready=%b required 0", inst_ready);
        end
        inst_valid = 1'b0;
        ertn_flush = 1'b1;
        #1;
        checks++;
        if (vaddr_ready !== 1'b0) begin
            failures++;
            $display("FAIL ertn_vready: got %b required 0", vaddr_ready);
        end
        tick();
        ertn_flush = 1'b0;
`ifdef IF_RESP_PERF_EN
        checks++;
        if (perf_drop_cnt !== 32'(exp_drops)) begin
            failures++;
            $display("FAIL excp_perf: got %0d required %0d", perf_drop_cnt, exp_drops);
        end
`endif
    endtask

    task automatic test_reset_mid();
        ib_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vaddr = 32'h1C00_0400 + 32'(i * 4);
            vaddr_valid = 1'b1;
            tick();
        end
        vaddr_valid = 1'b0;
        inst_i = 32'hFFFF_0001;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        checks++;
        if (ib_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pre: got ib_valid=%b required 1", ib_valid);
        end
        #2;
        reset = 1'b1;
        tick();
        checks++;
        if ({vaddr_ready, inst_ready, ib_valid} !== 3'b100 || inst_o !== '0 || vaddr_o !== '0) begin
            failures++;
            $display("FAIL rmid_outputs: got vr/ir/ibv=%b inst=%h addr=%h required 100/0/0",
                     {vaddr_ready, inst_ready, ib_valid}, inst_o, vaddr_o);
        end
        reset = 1'b0;
        exp_drops = 0;
        inst_i = 32'h1234_5678;
        inst_valid = 1'b1;
        ib_ready = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b0) begin
            failures++;
            $display("FAIL rmid_ignore: got inst_ready=%b required 0", inst_ready);
        end
        tick();
        inst_valid = 1'b0;
        checks++;
        if (ib_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_noout: got ib_valid=%b required 0", ib_valid);
        end
`ifdef IF_RESP_PERF_EN
        checks++;
        if (perf_drop_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rmid_perf: got %0d required 0", perf_drop_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_flush();
        test_stall();
        test_excp_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
